// File: rtl/ovl_fire_pkg.sv
// Shared types and constants for the checker fire monitor.
// Holds the monitor FSM state enum and fire bit positions.
package ovl_fire_pkg;

   typedef enum logic [1:0] {
      ST_RUN,
      ST_ALERT,
      ST_HALT
   } mon_state_t;

   localparam int FIRE_ASSERT = 0;
   localparam int FIRE_XCHECK = 1;
   localparam int FIRE_COVER  = 2;
   localparam int FIRE_BUS_W  = 3;

endpackage

// File: rtl/ovl_sat_accum.sv
// Popcount of n_bits inputs added into a saturating counter.
// Ports: clock, reset (async low), clear, en, bits in; count out.
module ovl_sat_accum #(
   parameter int n_bits      = 4,
   parameter int count_width = 8
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   clear,
   input  logic                   en,
   input  logic [n_bits-1:0]      bits,
   output logic [count_width-1:0] count
);

   localparam int pop_width = $clog2(n_bits + 1);
   localparam int sum_width =
      ((count_width > pop_width) ? count_width : pop_width) + 1;
   localparam logic [sum_width-1:0] max_sum =
      sum_width'({count_width{1'b1}});

   logic [pop_width-1:0]   pop;
   logic [sum_width-1:0]   sum;
   logic [count_width-1:0] next_count;

   always_comb begin
      pop = '0;
      for (int i = 0; i < n_bits; i++)
         pop = pop + pop_width'(bits[i]);
   end

   // One spare bit so the overflow is visible before clipping.
   assign sum = sum_width'(count) + sum_width'(pop);
   assign next_count = (sum > max_sum) ? '1 : count_width'(sum);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (en)
         count <= next_count;
   end

endmodule

// File: rtl/ovl_fire_monitor.sv
// Collects checker fire buses into counters, irq FSM, first-fail.
// Ports: clock, reset, enable, fire_in, clear, irq_ack in;
//        irq, *_count, first_fail_idx/valid, halted out.
module ovl_fire_monitor
   import ovl_fire_pkg::*;
#(
   parameter int num_checkers   = 4,
   parameter int count_width    = 8,
   parameter int idx_width      = 4,
   parameter int severity_level = 1
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      enable,
   input  logic [3*num_checkers-1:0] fire_in,
   input  logic                      clear,
   input  logic                      irq_ack,
   output logic                      irq,
   output logic [count_width-1:0]    assert_count,
   output logic [count_width-1:0]    xcheck_count,
   output logic [count_width-1:0]    cover_count,
   output logic [idx_width-1:0]      first_fail_idx,
   output logic                      first_fail_valid,
   output logic                      halted
);

   mon_state_t state;
   logic       armed;
   logic       clear_eff;
   logic       sample;
   logic       fail_any;

   logic [num_checkers-1:0] a_bits;
   logic [num_checkers-1:0] x_bits;
   logic [num_checkers-1:0] c_bits;
   logic [num_checkers-1:0] fail_bits;
   logic [idx_width-1:0]    low_idx;

   // Assertion is async; release is taken one edge later so the
   // first sample lands on the second rising edge after release.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         armed <= 1'b0;
      else
         armed <= 1'b1;
   end

   always_comb begin
      a_bits = '0;
      x_bits = '0;
      c_bits = '0;
      for (int k = 0; k < num_checkers; k++) begin
         a_bits[k] = fire_in[FIRE_BUS_W*k + FIRE_ASSERT];
         x_bits[k] = fire_in[FIRE_BUS_W*k + FIRE_XCHECK];
         c_bits[k] = fire_in[FIRE_BUS_W*k + FIRE_COVER];
      end
   end

   assign fail_bits = a_bits | x_bits;
   assign clear_eff = armed & clear;
   assign sample    = armed & enable & ~clear & (state != ST_HALT);
   assign fail_any  = sample & (|fail_bits);

   // Descending scan leaves the lowest firing index.
   always_comb begin
      low_idx = '0;
      for (int k = num_checkers - 1; k >= 0; k--)
         if (fail_bits[k])
            low_idx = idx_width'(k);
   end

   ovl_sat_accum #(
      .n_bits      (num_checkers),
      .count_width (count_width)
   ) u_assert_acc (
      .clock (clock),
      .reset (reset),
      .clear (clear_eff),
      .en    (sample),
      .bits  (a_bits),
      .count (assert_count)
   );

   ovl_sat_accum #(
      .n_bits      (num_checkers),
      .count_width (count_width)
   ) u_xcheck_acc (
      .clock (clock),
      .reset (reset),
      .clear (clear_eff),
      .en    (sample),
      .bits  (x_bits),
      .count (xcheck_count)
   );

   ovl_sat_accum #(
      .n_bits      (num_checkers),
      .count_width (count_width)
   ) u_cover_acc (
      .clock (clock),
      .reset (reset),
      .clear (clear_eff),
      .en    (sample),
      .bits  (c_bits),
      .count (cover_count)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state            <= ST_RUN;
         irq              <= 1'b0;
         halted           <= 1'b0;
         first_fail_idx   <= '0;
         first_fail_valid <= 1'b0;
      end else if (armed) begin
         if (clear) begin
            state            <= ST_RUN;
            irq              <= 1'b0;
            halted           <= 1'b0;
            first_fail_idx   <= '0;
            first_fail_valid <= 1'b0;
         end else begin
            if (fail_any && !first_fail_valid) begin
               first_fail_idx   <= low_idx;
               first_fail_valid <= 1'b1;
            end
            unique case (state)
               ST_RUN: begin
                  if (fail_any) begin
                     state <= ST_ALERT;
                     irq   <= 1'b1;
                  end
               end
               ST_ALERT: begin
                  if (irq_ack) begin
                     irq <= 1'b0;
                     if (severity_level == 0) begin
                        state  <= ST_HALT;
                        halted <= 1'b1;
                     end else begin
                        state <= ST_RUN;
                     end
                  end
               end
               ST_HALT: begin
                  halted <= 1'b1;
               end
               default: begin
                  state <= ST_RUN;
                  irq   <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_ovl_fire_monitor.sv
// Self-checking bench: a non-fatal and a fatal instance share
// stimulus; vectors, corner sequences and random vs. a model.
module tb_ovl_fire_monitor;

   localparam int NC = 4;
   localparam int CW = 8;
   localparam int IW = 4;
   localparam int CMAX = 255;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic enable = 1'b0;
   logic clear = 1'b0;
   logic irq_ack = 1'b0;
   logic [3*NC-1:0] fire_in = '0;

   logic          irq_o [2];
   logic [CW-1:0] ac_o  [2];
   logic [CW-1:0] xc_o  [2];
   logic [CW-1:0] cc_o  [2];
   logic [IW-1:0] ffi_o [2];
   logic          ffv_o [2];
   logic          hlt_o [2];

   int errors = 0;
   int checks = 0;

   int m_ac [2];
   int m_xc [2];
   int m_cc [2];
   int m_ffi[2];
   bit m_irq[2];
   bit m_ffv[2];
   bit m_hlt[2];

   typedef struct {
      logic        en;
      logic [11:0] fire;
      logic        clr;
      logic        ack;
      int          ac;
      int          xc;
      int          cc;
      logic        irq;
      logic        ffv;
      int          ffi;
   } vec_t;

   vec_t tbl [14];

   always #5 clock = ~clock;

   ovl_fire_monitor #(
      .num_checkers(NC), .count_width(CW),
      .idx_width(IW), .severity_level(1)
   ) u_nf (
      .clock(clock), .reset(reset), .enable(enable),
      .fire_in(fire_in), .clear(clear), .irq_ack(irq_ack),
      .irq(irq_o[0]), .assert_count(ac_o[0]),
      .xcheck_count(xc_o[0]), .cover_count(cc_o[0]),
      .first_fail_idx(ffi_o[0]),
      .first_fail_valid(ffv_o[0]), .halted(hlt_o[0])
   );

   ovl_fire_monitor #(
      .num_checkers(NC), .count_width(CW),
      .idx_width(IW), .severity_level(0)
   ) u_ft (
      .clock(clock), .reset(reset), .enable(enable),
      .fire_in(fire_in), .clear(clear), .irq_ack(irq_ack),
      .irq(irq_o[1]), .assert_count(ac_o[1]),
      .xcheck_count(xc_o[1]), .cover_count(cc_o[1]),
      .first_fail_idx(ffi_o[1]),
      .first_fail_valid(ffv_o[1]), .halted(hlt_o[1])
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_ac[i] = 0; m_xc[i] = 0; m_cc[i] = 0; m_ffi[i] = 0;
         m_irq[i] = 0; m_ffv[i] = 0; m_hlt[i] = 0;
      end
   endtask

   // Instance 1 is the fatal one: acknowledge leads to halt.
   task automatic model_step();
      int na, nx, nc, low;
      for (int i = 0; i < 2; i++) begin
         if (clear) begin
            m_ac[i] = 0; m_xc[i] = 0; m_cc[i] = 0; m_ffi[i] = 0;
            m_irq[i] = 0; m_ffv[i] = 0; m_hlt[i] = 0;
            continue;
         end
         if (m_hlt[i]) continue;
         na = 0; nx = 0; nc = 0; low = -1;
         if (enable) begin
            for (int k = 0; k < NC; k++) begin
               na += int'(fire_in[3*k]);
               nx += int'(fire_in[3*k+1]);
               nc += int'(fire_in[3*k+2]);
               if ((fire_in[3*k] || fire_in[3*k+1]) && low < 0)
                  low = k;
            end
         end
         m_ac[i] = (m_ac[i] + na > CMAX) ? CMAX : m_ac[i] + na;
         m_xc[i] = (m_xc[i] + nx > CMAX) ? CMAX : m_xc[i] + nx;
         m_cc[i] = (m_cc[i] + nc > CMAX) ? CMAX : m_cc[i] + nc;
         if (!m_ffv[i] && low >= 0) begin
            m_ffv[i] = 1;
            m_ffi[i] = low;
         end
         if (m_irq[i]) begin
            if (irq_ack) begin
               m_irq[i] = 0;
               m_hlt[i] = (i == 1);
            end
         end else if (low >= 0) begin
            m_irq[i] = 1;
         end
      end
   endtask

   task automatic check_model(input string tag);
      for (int i = 0; i < 2; i++) begin
         chk($sformatf("%s_u%0d_ac", tag, i), 32'(ac_o[i]), m_ac[i]);
         chk($sformatf("%s_u%0d_xc", tag, i), 32'(xc_o[i]), m_xc[i]);
         chk($sformatf("%s_u%0d_cc", tag, i), 32'(cc_o[i]), m_cc[i]);
         chk($sformatf("%s_u%0d_irq", tag, i), 32'(irq_o[i]),
             32'(m_irq[i]));
         chk($sformatf("%s_u%0d_ffv", tag, i), 32'(ffv_o[i]),
             32'(m_ffv[i]));
         chk($sformatf("%s_u%0d_ffi", tag, i), 32'(ffi_o[i]),
             m_ffi[i]);
         chk($sformatf("%s_u%0d_hlt", tag, i), 32'(hlt_o[i]),
             32'(m_hlt[i]));
      end
   endtask

   // Called at a falling edge; returns at the next falling edge.
   task automatic apply(input logic en, input logic [11:0] f,
                        input logic clr, input logic ack,
                        input string tag);
      enable = en; fire_in = f; clear = clr; irq_ack = ack;
      @(posedge clock);
      model_step();
      @(negedge clock);
      check_model(tag);
   endtask

   initial begin
      tbl[0]  = '{1'b1, 12'h000, 1'b0, 1'b0, 0, 0, 0, 1'b0, 1'b0, 0};
      tbl[1]  = '{1'b1, 12'h208, 1'b0, 1'b0, 2, 0, 0, 1'b1, 1'b1, 1};
      tbl[2]  = '{1'b1, 12'h000, 1'b0, 1'b0, 2, 0, 0, 1'b1, 1'b1, 1};
      tbl[3]  = '{1'b1, 12'h004, 1'b0, 1'b0, 2, 0, 1, 1'b1, 1'b1, 1};
      tbl[4]  = '{1'b1, 12'h080, 1'b0, 1'b1, 2, 1, 1, 1'b0, 1'b1, 1};
      tbl[5]  = '{1'b1, 12'h000, 1'b0, 1'b0, 2, 1, 1, 1'b0, 1'b1, 1};
      tbl[6]  = '{1'b1, 12'h000, 1'b0, 1'b1, 2, 1, 1, 1'b0, 1'b1, 1};
      tbl[7]  = '{1'b0, 12'hFFF, 1'b0, 1'b0, 2, 1, 1, 1'b0, 1'b1, 1};
      tbl[8]  = '{1'b1, 12'h002, 1'b0, 1'b0, 2, 2, 1, 1'b1, 1'b1, 1};
      tbl[9]  = '{1'b1, 12'h001, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 0};
      tbl[10] = '{1'b1, 12'h440, 1'b0, 1'b0, 1, 1, 0, 1'b1, 1'b1, 2};
      tbl[11] = '{1'b0, 12'h000, 1'b0, 1'b1, 1, 1, 0, 1'b0, 1'b1, 2};
      tbl[12] = '{1'b1, 12'hFFF, 1'b0, 1'b0, 5, 5, 4, 1'b1, 1'b1, 2};
      tbl[13] = '{1'b1, 12'h000, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b0, 0};

      // Reset state
      reset = 1'b0;
      repeat (2) @(negedge clock);
      model_reset();
      check_model("reset");

      // First edge after release is not sampled, second one is.
      enable = 1'b1; fire_in = 12'h001;
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      chk("sync_edge1_ignored", 32'(ac_o[0]), 0);
      @(posedge clock);
      model_step();
      @(negedge clock);
      check_model("sync");
      chk("sync_edge2_sampled", 32'(ac_o[0]), 1);
      apply(1'b1, 12'h000, 1'b1, 1'b0, "clr0");

      // Vector table against the non-fatal instance
      for (int t = 0; t < 14; t++) begin
         apply(tbl[t].en, tbl[t].fire, tbl[t].clr, tbl[t].ack,
               $sformatf("tbl%0d", t));
         chk($sformatf("tbl%0d_ac", t), 32'(ac_o[0]), tbl[t].ac);
         chk($sformatf("tbl%0d_xc", t), 32'(xc_o[0]), tbl[t].xc);
         chk($sformatf("tbl%0d_cc", t), 32'(cc_o[0]), tbl[t].cc);
         chk($sformatf("tbl%0d_irq", t), 32'(irq_o[0]),
             32'(tbl[t].irq));
         chk($sformatf("tbl%0d_ffv", t), 32'(ffv_o[0]),
             32'(tbl[t].ffv));
         chk($sformatf("tbl%0d_ffi", t), 32'(ffi_o[0]), tbl[t].ffi);
      end

      // Cover saturation
      repeat (300) apply(1'b1, 12'h924, 1'b0, 1'b0, "sat");
      chk("sat_cover", 32'(cc_o[0]), 255);
      chk("sat_irq", 32'(irq_o[0]), 0);
      apply(1'b1, 12'h000, 1'b1, 1'b0, "clr1");

      // Fatal instance halts and freezes until clear
      apply(1'b1, 12'h002, 1'b0, 1'b0, "hlt_fire");
      chk("hlt_irq", 32'(irq_o[1]), 1);
      apply(1'b1, 12'h000, 1'b0, 1'b1, "hlt_ack");
      chk("hlt_halted", 32'(hlt_o[1]), 1);
      repeat (3) apply(1'b1, 12'hFFF, 1'b0, 1'b0, "hlt_frz");
      chk("hlt_frz_xc", 32'(xc_o[1]), 1);
      chk("hlt_frz_ac", 32'(ac_o[1]), 0);
      chk("hlt_frz_cc", 32'(cc_o[1]), 0);
      apply(1'b1, 12'h000, 1'b1, 1'b0, "hlt_clr");
      chk("hlt_clr_halted", 32'(hlt_o[1]), 0);
      chk("hlt_clr_xc", 32'(xc_o[1]), 0);

      // Disabled sampling
      repeat (10) apply(1'b0, 12'hFFF, 1'b0, 1'b0, "dis");
      chk("dis_ac", 32'(ac_o[0]), 0);
      chk("dis_xc", 32'(xc_o[0]), 0);
      chk("dis_cc", 32'(cc_o[0]), 0);
      chk("dis_irq", 32'(irq_o[0]), 0);

      // Asynchronous reset while alerting
      apply(1'b1, 12'h249, 1'b0, 1'b0, "ar1");
      apply(1'b1, 12'h001, 1'b0, 1'b0, "ar2");
      chk("ar_pre_ac", 32'(ac_o[0]), 5);
      chk("ar_pre_irq", 32'(irq_o[0]), 1);
      #2 reset = 1'b0;
      #1;
      chk("ar_ac", 32'(ac_o[0]), 0);
      chk("ar_irq", 32'(irq_o[0]), 0);
      chk("ar_ffv", 32'(ffv_o[0]), 0);
      chk("ar_hlt", 32'(hlt_o[0]), 0);
      model_reset();
      @(negedge clock);
      check_model("ar_hold");
      enable = 1'b0; fire_in = '0; clear = 1'b0; irq_ack = 1'b0;
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);

      // Random traffic
      repeat (3000) begin
         apply(logic'($urandom_range(0, 9) != 0),
               12'($urandom & $urandom & $urandom),
               logic'($urandom_range(0, 99) == 0),
               logic'($urandom_range(0, 3) == 0), "rnd");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
